// File: rtl/axis_fifo_pkg.sv
// ----------------------------------------------------------------------------
// axis_fifo_pkg
// Shared types and helpers for the AXI-Stream packet FIFO.
//   AXIS_DATA_WIDTH : tdata width the stored-beat layout is built for; the
//                     FIFO's DATA_WIDTH parameter defaults to it and must match.
//   axis_beat_t     : one stored beat (data, keep, last), packed.
//   pkt_state_e     : write-side state used in store-and-forward builds.
//   ptr_width()     : pointer width for a given depth (address bits + wrap bit).
// ----------------------------------------------------------------------------
package axis_fifo_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0]   data;
        logic [AXIS_DATA_WIDTH/8-1:0] keep;
        logic                         last;
    } axis_beat_t;

    // StDiscard swallows the tail of a packet that could never fit.
    typedef enum logic {
        StPass,
        StDiscard
    } pkt_state_e;

    // The extra MSB tells a full FIFO apart from an empty one.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_packet_fifo_if.sv
// ----------------------------------------------------------------------------
// axis_packet_fifo_if
// One AXI-Stream channel: tvalid/tready handshake plus tdata/tkeep/tlast.
//   master modport : drives tvalid, tdata, tkeep, tlast; samples tready.
//   slave modport  : samples tvalid, tdata, tkeep, tlast; drives tready.
// ----------------------------------------------------------------------------
interface axis_packet_fifo_if
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH
) ();

    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_fifo_ram.sv
// ----------------------------------------------------------------------------
// axis_fifo_ram
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port, single clock. The asynchronous read lets the FIFO present the head
// entry in the cycle right after it was written.
//   clk_i     : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : contents at rd_addr_i
// ----------------------------------------------------------------------------
module axis_fifo_ram #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [Width-1:0]     wr_data_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [Width-1:0]     rd_data_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_packet_fifo.sv
// ----------------------------------------------------------------------------
// axis_packet_fifo
// First-word-fall-through AXI-Stream FIFO with occupancy and threshold flags.
// Build option: define AXIS_PKT_FIFO_PACKET_MODE_EN for store-and-forward
// operation (a packet is only offered downstream once its tlast beat is stored,
// and a packet that fills the FIFO on its own is dropped). Without the macro the
// FIFO is cut-through and drop_pulse is tied low.
//   axis_clk     : clock (rising edge)
//   axis_rst     : synchronous active-high reset
//   s_axis       : upstream channel (slave modport)
//   m_axis       : downstream channel (master modport)
//   occupancy    : stored beats, registered
//   almost_full  : occupancy >= ALMOST_FULL_LVL, registered
//   almost_empty : occupancy <= ALMOST_EMPTY_LVL, registered
//   drop_pulse   : one-cycle pulse per discarded packet
// ----------------------------------------------------------------------------
module axis_packet_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = AXIS_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH       = 256,
    parameter int unsigned ALMOST_FULL_LVL  = FIFO_DEPTH - 4,
    parameter int unsigned ALMOST_EMPTY_LVL = 4
) (
    input  logic                              axis_clk,
    input  logic                              axis_rst,
    axis_packet_fifo_if.slave                 s_axis,
    axis_packet_fifo_if.master                m_axis,
    output logic [ptr_width(FIFO_DEPTH)-1:0]  occupancy,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic                              drop_pulse
);

    localparam int unsigned PW = ptr_width(FIFO_DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [PW-1:0] AfLvl   = PW'(ALMOST_FULL_LVL);
    localparam logic [PW-1:0] AeLvl   = PW'(ALMOST_EMPTY_LVL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] occ_q, occ_d;
    logic          almost_full_q, almost_full_d;
    logic          almost_empty_q, almost_empty_d;

    logic          full;
    logic          s_ready;
    logic          m_valid;
    logic          wr_fire;
    logic          rd_fire;
    logic          mem_we;
    axis_beat_t    wr_beat;
    axis_beat_t    rd_beat;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    always_comb begin
        wr_beat      = '0;
        wr_beat.data = s_axis.tdata[DATA_WIDTH-1:0];
        wr_beat.keep = s_axis.tkeep[DATA_WIDTH/8-1:0];
        wr_beat.last = s_axis.tlast;
    end

    axis_fifo_ram #(
        .Width ($bits(axis_beat_t)),
        .Depth (FIFO_DEPTH)
    ) u_ram (
        .clk_i     (axis_clk),
        .wr_en_i   (mem_we),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_beat),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_beat)
    );

    // ------------------------------------------------------------------------
    // Handshakes, pointers and status
    // ------------------------------------------------------------------------
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire  = s_axis.tvalid && s_ready;
    assign rd_fire  = m_valid && m_axis.tready;
    assign rd_ptr_d = rd_ptr_q + PW'(rd_fire);

    // Status is derived from next-state pointers so the registered flags
    // reflect exactly the transfers of the cycle just completed.
    always_comb begin
        occ_d          = wr_ptr_d - rd_ptr_d;
        almost_full_d  = (occ_d >= AfLvl);
        almost_empty_d = (occ_d <= AeLvl);
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
    // ------------------------------------------------------------------------
    // Store-and-forward write control
    // ------------------------------------------------------------------------
    pkt_state_e    state_q, state_d;
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [PW-1:0] pkt_start_q, pkt_start_d;
    logic          drop_q, drop_d;
    logic          commit;

    // While discarding, beats are accepted regardless of fill level.
    assign s_ready    = !axis_rst && (!full || (state_q == StDiscard));
    // Only whole packets are offered, so the reader never enters a partial one.
    assign m_valid    = !axis_rst && (pkt_cnt_q != '0);
    assign drop_pulse = drop_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        pkt_start_d = pkt_start_q;
        mem_we      = 1'b0;
        drop_d      = 1'b0;
        commit      = 1'b0;
        unique case (state_q)
            StPass: begin
                if (wr_fire) begin
                    if (s_axis.tlast) begin
                        mem_we      = 1'b1;
                        wr_ptr_d    = wr_ptr_q + PtrOne;
                        pkt_start_d = wr_ptr_q + PtrOne;
                        commit      = 1'b1;
                    end else if ((pkt_cnt_q == '0) && (occ_q == PW'(FIFO_DEPTH - 1))) begin
                        // This beat would fill the FIFO with one unfinished packet and
                        // nothing readable: it can never complete, so rewind and drop it.
                        // With no committed packets the read pointer sits at pkt_start.
                        wr_ptr_d = pkt_start_q;
                        drop_d   = 1'b1;
                        state_d  = StDiscard;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrOne;
                    end
                end
            end
            StDiscard: begin
                if (wr_fire && s_axis.tlast) begin
                    state_d = StPass;
                end
            end
            default: state_d = StPass;
        endcase
        // A tlast written and a tlast read in the same cycle cancel out.
        pkt_cnt_d = pkt_cnt_q + PW'(commit) - PW'(rd_fire && rd_beat.last);
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q     <= StPass;
            pkt_cnt_q   <= '0;
            pkt_start_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_cnt_q   <= pkt_cnt_d;
            pkt_start_q <= pkt_start_d;
            drop_q      <= drop_d;
        end
    end
`else
    // ------------------------------------------------------------------------
    // Cut-through write control
    // ------------------------------------------------------------------------
    logic empty;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign s_ready    = !axis_rst && !full;
    assign m_valid    = !axis_rst && !empty;
    assign mem_we     = wr_fire;
    assign wr_ptr_d   = wr_ptr_q + PW'(wr_fire);
    assign drop_pulse = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs; payload is zeroed whenever nothing is offered (incl. reset)
    // ------------------------------------------------------------------------
    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_valid ? rd_beat.data : '0;
    assign m_axis.tkeep  = m_valid ? rd_beat.keep : '0;
    assign m_axis.tlast  = m_valid && rd_beat.last;

    assign occupancy     = occ_q;
    assign almost_full   = almost_full_q;
    assign almost_empty  = almost_empty_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// ----------------------------------------------------------------------------
// tb_axis_packet_fifo
// Self-checking bench for axis_packet_fifo. A queue-based reference model of
// the stream contents predicts occupancy, flags, handshakes and every output
// beat; checks run once per cycle shortly after the rising edge.
// Define AXIS_PKT_FIFO_PACKET_MODE_EN to exercise the store-and-forward build.
// ----------------------------------------------------------------------------
module tb_axis_packet_fifo;
    import axis_fifo_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AF    = DEPTH - 4;
    localparam int unsigned AE    = 4;
    localparam int unsigned BW    = DW + KW + 1;
`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
    localparam bit PktMode = 1'b1;
`else
    localparam bit PktMode = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ptr_width(DEPTH)-1:0] occupancy;
    logic almost_full;
    logic almost_empty;
    logic drop_pulse;

    axis_packet_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    axis_packet_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    always #5 clk = ~clk;

    axis_packet_fifo #(
        .DATA_WIDTH       (DW),
        .FIFO_DEPTH       (DEPTH),
        .ALMOST_FULL_LVL  (AF),
        .ALMOST_EMPTY_LVL (AE)
    ) dut (
        .axis_clk     (clk),
        .axis_rst     (rst),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .occupancy    (occupancy),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .drop_pulse   (drop_pulse)
    );

    // Reference model: outq holds beats that may be read (in order), curq the
    // unfinished packet in store-and-forward mode. Beats pack as {data,keep,last}.
    logic [BW-1:0] outq[$];
    logic [BW-1:0] curq[$];
    int            n_pkts;
    bit            discarding;
    bit            exp_drop;
    int            n_checks;
    int            n_errors;
    int            drop_seen;

    function automatic int unsigned model_occ();
        return outq.size() + curq.size();
    endfunction

    function automatic logic exp_s_ready();
        return !rst && (discarding || (model_occ() < DEPTH));
    endfunction

    function automatic logic exp_m_valid();
        if (rst) return 1'b0;
        return PktMode ? (n_pkts > 0) : (outq.size() > 0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_beat(input logic [BW-1:0] b);
        if (!PktMode) begin
            outq.push_back(b);
            if (b[0]) n_pkts++;
        end else if (discarding) begin
            if (b[0]) discarding = 1'b0;
        end else begin
            curq.push_back(b);
            if (b[0]) begin
                while (curq.size() > 0) outq.push_back(curq.pop_front());
                n_pkts++;
            end else if (model_occ() == DEPTH && n_pkts == 0) begin
                curq.delete();
                discarding = 1'b1;
                exp_drop   = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        int unsigned occ;
        logic        mv;
        occ = model_occ();
        mv  = exp_m_valid();
        check("occupancy", 64'(occupancy), 64'(occ));
        check("almost_full", 64'(almost_full), 64'(occ >= AF));
        check("almost_empty", 64'(almost_empty), 64'(occ <= AE));
        check("s_tready", 64'(s_if.tready), 64'(exp_s_ready()));
        check("m_tvalid", 64'(m_if.tvalid), 64'(mv));
        check("drop_pulse", 64'(drop_pulse), 64'(exp_drop));
        if (mv) check("m_beat", 64'({m_if.tdata, m_if.tkeep, m_if.tlast}), 64'(outq[0]));
        if (rst) check("rst_beat", 64'({m_if.tdata, m_if.tkeep, m_if.tlast}), 64'(0));
        if (drop_pulse === 1'b1) drop_seen++;
    endtask

    // One clock: decide transfers from the model just before the edge, then check.
    task automatic cycle();
        logic          s_fire;
        logic          m_fire;
        logic [BW-1:0] b;
        @(negedge clk);
        if (rst) begin
            outq.delete();
            curq.delete();
            n_pkts     = 0;
            discarding = 1'b0;
            exp_drop   = 1'b0;
        end else begin
            s_fire   = s_if.tvalid && exp_s_ready();
            m_fire   = m_if.tready && exp_m_valid();
            exp_drop = 1'b0;
            if (m_fire) begin
                b = outq.pop_front();
                if (b[0]) n_pkts--;
            end
            if (s_fire) push_beat({s_if.tdata, s_if.tkeep, s_if.tlast});
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                         input logic l, input logic r);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        m_if.tready = r;
        cycle();
    endtask

    task automatic drain();
        for (int n = 0; (n < 2 * DEPTH + 8) && (outq.size() > 0); n++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
        end
        check("drained_tvalid", 64'(m_if.tvalid), 64'(0));
        check("drained_occupancy", 64'(occupancy), 64'(curq.size()));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = $urandom;
        m_if.tready = 1'b1;
        cycle();
        cycle();
        rst         = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        check("tready_after_reset", 64'(s_if.tready), 64'(1));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        drop_seen   = 0;
        n_pkts      = 0;
        discarding  = 1'b0;
        exp_drop    = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;

        // Reset values with inputs active
        do_reset();

        // Fill to the brim with the reader stalled, then try one more beat
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, DW'(i), KW'($urandom), (i == 255), 1'b0);
        end
        drive(1'b1, 32'hdead_beef, 4'hf, 1'b0, 1'b0);
        check("full_occupancy", 64'(occupancy), 64'(256));
        check("full_almost_full", 64'(almost_full), 64'(1));
        check("full_s_tready", 64'(s_if.tready), 64'(0));

        // Read everything back in order
        drain();
        check("empty_almost_empty", 64'(almost_empty), 64'(1));

        // Streaming: one beat in and one out per cycle
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, $urandom, KW'($urandom), ((i % 8) == 7), 1'b1);
        end
        drain();

        // Random valid/ready with random packet boundaries
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 7), $urandom, KW'($urandom),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        drive(1'b1, $urandom, 4'hf, 1'b1, 1'b1);
        drain();

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
        // 8-beat packet stays invisible until its tlast is stored
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(100 + i), 4'hf, (i == 7), 1'b1);
            check("pkt8_tvalid", 64'(m_if.tvalid), 64'(i == 7));
        end
        drain();

        // 300-beat packet cannot fit: dropped once, next packet intact
        drop_seen = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, DW'(i), 4'hf, (i == 299), 1'b1);
        end
        check("drop_occupancy", 64'(occupancy), 64'(0));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(32'hc0de_0000 + i), KW'(i), (i == 3), 1'b1);
        end
        drain();
        check("drop_count", 64'(drop_seen), 64'(1));
`endif

        // Reset in the middle of a packet discards everything
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'(i), 4'hf, 1'b0, 1'b0);
        end
        do_reset();
        check("reset_occupancy", 64'(occupancy), 64'(0));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(32'h5a00 + i), 4'h3, (i == 2), 1'b0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
